sram_dp_burst: RTL and testbench

//  Parametrised dual-port on-chip SRAM, successor to the simple DP model. Bus port: valid/ready

---
 rtl/sram_dp_pkg.sv | 16 +
 rtl/sram_dp_burst_if.sv | 52 +++++
 rtl/sram_dp_skid_buf.sv | 74 +++++++
 rtl/sram_dp_burst.sv | 219 +++++++++++++++++++++
 tb/tb_sram_dp_burst.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_dp_pkg.sv
// Shared types and helpers for the dual-port burst SRAM.
// Optional per-byte parity is enabled by defining SRAM_DP_PARITY_EN.
package sram_dp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dma_state_e;

    // Even parity of one byte: the stored bit makes the 9-bit group have an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sram_dp_burst_if.sv
// Bus and DMA-stream signal bundle for sram_dp_burst.
// Parity status outputs exist only when SRAM_DP_PARITY_EN is defined.
interface sram_dp_burst_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  req_err;

    logic                  dma_start;
    logic [31:0]           dma_addr;
    logic [LEN_W-1:0]      dma_len;
    logic                  dma_abort;
    logic                  dma_busy;
    logic                  dma_done;
    logic                  dma_valid;
    logic                  dma_ready;
    logic [DATA_W-1:0]     dma_data;
    logic                  dma_last;
`ifdef SRAM_DP_PARITY_EN
    logic                  rd_par_err;
    logic                  dma_par_err;
`endif

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output dma_start, dma_addr, dma_len, dma_abort, dma_ready,
        input  req_ready, rvalid, rdata, req_err,
        input  dma_busy, dma_done, dma_valid, dma_data, dma_last
`ifdef SRAM_DP_PARITY_EN
        , input rd_par_err, dma_par_err
`endif
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  dma_start, dma_addr, dma_len, dma_abort, dma_ready,
        output req_ready, rvalid, rdata, req_err,
        output dma_busy, dma_done, dma_valid, dma_data, dma_last
`ifdef SRAM_DP_PARITY_EN
        , output rd_par_err, dma_par_err
`endif
    );

endinterface

// File: rtl/sram_dp_skid_buf.sv
// Two-entry valid/ready buffer holding memory read words for the DMA stream.
// Entry 0 is always the presented word; flush empties it in one cycle.
module sram_dp_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] ent0_r;
    logic [W-1:0] ent1_r;
    logic [1:0]   cnt_r;
    logic         pop_s;
    logic         push_s;

    // Space exists if not full, or if the head leaves this cycle.
    always_comb begin
        pop_s     = (cnt_r != 2'd0) & out_ready;
        in_ready  = (cnt_r != 2'd2) | pop_s;
        push_s    = in_valid & in_ready;
        out_valid = (cnt_r != 2'd0);
        out_data  = ent0_r;
    end

    // Occupancy and entry storage; the head only moves on a pop so stalled data stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_r <= {W{1'b0}};
            ent1_r <= {W{1'b0}};
            cnt_r  <= 2'd0;
        end else if (flush) begin
            cnt_r <= 2'd0;
        end else begin
            case (cnt_r)
                2'd0: begin
                    if (push_s) begin
                        ent0_r <= in_data;
                        cnt_r  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push_s, pop_s})
                        2'b11:   ent0_r <= in_data;
                        2'b10: begin
                            ent1_r <= in_data;
                            cnt_r  <= 2'd2;
                        end
                        2'b01:   cnt_r <= 2'd0;
                        default: cnt_r <= cnt_r;
                    endcase
                end
                2'd2: begin
                    if (pop_s) begin
                        ent0_r <= ent1_r;
                        if (push_s) begin
                            ent1_r <= in_data;
                        end else begin
                            cnt_r <= 2'd1;
                        end
                    end
                end
                default: cnt_r <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/sram_dp_burst.sv
// Dual-port SRAM: byte-strobed bus port plus an autonomous DMA read-burst streamer.
// Define SRAM_DP_PARITY_EN to store per-byte even parity and report read mismatches.
module sram_dp_burst
    import sram_dp_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 16384,
    parameter int MAX_BURST = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_dp_burst_if.slave bus
);

    localparam int NB    = DATA_W / 8;
    localparam int BW    = $clog2(NB);
    localparam int DEPTH = MEM_BYTES / NB;
    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = $clog2(MAX_BURST) + 1;
`ifdef SRAM_DP_PARITY_EN
    localparam int MW    = DATA_W + NB;
    localparam int PW    = DATA_W + 2;
`else
    localparam int MW    = DATA_W;
    localparam int PW    = DATA_W + 1;
`endif

    logic [MW-1:0]    mem_r [DEPTH];

    logic             bus_in_range_s;
    logic             bus_wr_s;
    logic             bus_rd_s;
    logic [AW-1:0]    bus_idx_s;
    logic             req_ready_r;
    logic             rvalid_r;
    logic [DATA_W-1:0] rdata_r;
    logic             req_err_r;

    dma_state_e       state_r;
    logic [AW-1:0]    dma_idx_r;
    logic [LEN_W-1:0] remain_r;
    logic             done_r;
    logic             busy_r;
    logic [LEN_W-1:0] len_eff_s;
    logic             abort_s;
    logic             issue_s;
    logic             pop_s;
    logic [MW-1:0]    dma_word_s;
    logic [PW-1:0]    push_data_s;
    logic             buf_in_ready_s;
    logic             buf_out_valid_s;
    logic [PW-1:0]    buf_out_data_s;
    logic             unused_s;

`ifdef SRAM_DP_PARITY_EN
    logic             rd_par_err_r;

    // Any byte whose stored parity bit disagrees with its data flags the whole word.
    function automatic logic word_par_err(input logic [MW-1:0] w);
        logic err;
        err = 1'b0;
        for (int b = 0; b < NB; b++) begin
            err = err | (byte_parity(w[b*8 +: 8]) ^ w[DATA_W+b]);
        end
        return err;
    endfunction
`endif

    // Bus request decode; req_ready is always high so every valid is an accepted access.
    always_comb begin
        bus_in_range_s = (bus.req_addr < 32'(MEM_BYTES));
        bus_idx_s      = bus.req_addr[AW+BW-1:BW];
        bus_wr_s       = bus.req_valid & bus.req_write & bus_in_range_s;
        bus_rd_s       = bus.req_valid & ~bus.req_write;
    end

    // Array write port; out-of-range writes are dropped before reaching it.
    always_ff @(posedge clk) begin
        if (bus_wr_s) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.req_wstrb[b]) begin
                    mem_r[bus_idx_s][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
`ifdef SRAM_DP_PARITY_EN
                    mem_r[bus_idx_s][DATA_W+b] <= byte_parity(bus.req_wdata[b*8 +: 8]);
`endif
                end
            end
        end
    end

    // Registered bus read response and error pulse; rdata holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r <= 1'b1;
            rvalid_r    <= 1'b0;
            rdata_r     <= {DATA_W{1'b0}};
            req_err_r   <= 1'b0;
`ifdef SRAM_DP_PARITY_EN
            rd_par_err_r <= 1'b0;
`endif
        end else begin
            req_ready_r <= 1'b1;
            rvalid_r    <= bus_rd_s;
            req_err_r   <= bus.req_valid & ~bus_in_range_s;
            if (bus_rd_s) begin
                if (bus_in_range_s) begin
                    rdata_r <= mem_r[bus_idx_s][DATA_W-1:0];
                end else begin
                    rdata_r <= {DATA_W{1'b0}};
                end
            end
`ifdef SRAM_DP_PARITY_EN
            rd_par_err_r <= bus_rd_s & bus_in_range_s & word_par_err(mem_r[bus_idx_s]);
`endif
        end
    end

    // DMA read issue: the buffer entry is the read register, so a same-cycle bus write is seen as old data.
    always_comb begin
        len_eff_s   = (bus.dma_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : bus.dma_len;
        abort_s     = bus.dma_abort & (state_r != IDLE);
        issue_s     = (state_r == RUN) & buf_in_ready_s & ~bus.dma_abort;
        pop_s       = buf_out_valid_s & bus.dma_ready;
        dma_word_s  = mem_r[dma_idx_r];
        push_data_s = {PW{1'b0}};
        push_data_s[DATA_W-1:0] = dma_word_s[DATA_W-1:0];
        push_data_s[DATA_W]     = (remain_r == LEN_W'(1));
`ifdef SRAM_DP_PARITY_EN
        push_data_s[DATA_W+1]   = word_par_err(dma_word_s);
`endif
    end

    // Burst control FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            dma_idx_r <= {AW{1'b0}};
            remain_r  <= {LEN_W{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.dma_start & ~bus.dma_abort) begin
                        if (len_eff_s == {LEN_W{1'b0}}) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r   <= RUN;
                            busy_r    <= 1'b1;
                            dma_idx_r <= bus.dma_addr[AW+BW-1:BW];
                            remain_r  <= len_eff_s;
                        end
                    end
                end
                RUN: begin
                    if (abort_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (issue_s) begin
                        dma_idx_r <= dma_idx_r + AW'(1);
                        remain_r  <= remain_r - LEN_W'(1);
                        if (remain_r == LEN_W'(1)) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (abort_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (pop_s & buf_out_data_s[DATA_W]) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    sram_dp_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort_s),
        .in_valid  (issue_s),
        .in_ready  (buf_in_ready_s),
        .in_data   (push_data_s),
        .out_valid (buf_out_valid_s),
        .out_ready (bus.dma_ready),
        .out_data  (buf_out_data_s)
    );

    assign bus.req_ready = req_ready_r;
    assign bus.rvalid    = rvalid_r;
    assign bus.rdata     = rdata_r;
    assign bus.req_err   = req_err_r;
    assign bus.dma_busy  = busy_r;
    assign bus.dma_done  = done_r;
    assign bus.dma_valid = buf_out_valid_s;
    assign bus.dma_data  = buf_out_data_s[DATA_W-1:0];
    assign bus.dma_last  = buf_out_data_s[DATA_W];
`ifdef SRAM_DP_PARITY_EN
    assign bus.rd_par_err  = rd_par_err_r;
    assign bus.dma_par_err = buf_out_data_s[DATA_W+1] & buf_out_valid_s;
`endif

    // Word-offset address bits and bits above the array are intentionally ignored.
    assign unused_s = ^{bus.req_addr[BW-1:0], bus.dma_addr[31:AW+BW], bus.dma_addr[BW-1:0]};

endmodule

// File: tb/tb_sram_dp_burst.sv
// Directed + randomized bench for sram_dp_burst against a byte-array reference model.
module tb_sram_dp_burst;

    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 16384;
    localparam int MAX_BURST = 256;
    localparam int LEN_W     = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] mref [MEM_BYTES];

    sram_dp_burst_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bif ();

    sram_dp_burst #(
        .DATA_W    (DATA_W),
        .MEM_BYTES (MEM_BYTES),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int a;
        if (addr >= 32'(MEM_BYTES)) return 32'h0;
        a = int'(addr & 32'hFFFF_FFFC);
        return {mref[a+3], mref[a+2], mref[a+1], mref[a]};
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] d,
                                        input logic [3:0] strb);
        int a;
        if (addr < 32'(MEM_BYTES)) begin
            a = int'(addr & 32'hFFFF_FFFC);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mref[a+b] = d[b*8 +: 8];
            end
        end
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb);
        @(negedge clk);
        bif.req_valid = 1'b1; bif.req_write = 1'b1;
        bif.req_addr = addr; bif.req_wdata = d; bif.req_wstrb = strb;
        @(negedge clk);
        bif.req_valid = 1'b0; bif.req_write = 1'b0;
        model_write(addr, d, strb);
        check("wr_err", 32'(bif.req_err), 32'(addr >= 32'(MEM_BYTES)));
        check("wr_no_rvalid", 32'(bif.rvalid), 32'h0);
    endtask

    task automatic bus_read(input logic [31:0] addr, input string tag);
        logic [31:0] e;
        e = model_read(addr);
        @(negedge clk);
        bif.req_valid = 1'b1; bif.req_write = 1'b0; bif.req_addr = addr;
        @(negedge clk);
        bif.req_valid = 1'b0;
        check({tag, "_rvalid"}, 32'(bif.rvalid), 32'h1);
        check({tag, "_rdata"}, bif.rdata, e);
        check({tag, "_err"}, 32'(bif.req_err), 32'(addr >= 32'(MEM_BYTES)));
`ifdef SRAM_DP_PARITY_EN
        check({tag, "_par"}, 32'(bif.rd_par_err), 32'h0);
`endif
    endtask

    // Run one burst; abort_after<0 means no abort; collide bus-writes word 0 during its read.
    task automatic run_burst(input logic [31:0] addr, input int len, input bit rnd,
                             input int abort_after, input bit collide);
        int n_eff, got, last_hs, it;
        bit prev_stall, fin;
        logic r;
        logic [31:0] prev_data, base, cdata;
        logic [31:0] exp_q [$];
        n_eff = (len > MAX_BURST) ? MAX_BURST : len;
        base = (addr % 32'(MEM_BYTES)) & 32'hFFFF_FFFC;
        for (int k = 0; k < n_eff; k++) begin
            exp_q.push_back(model_read((base + 32'(4 * k)) % 32'(MEM_BYTES)));
        end
        @(negedge clk);
        bif.dma_start = 1'b1; bif.dma_addr = addr; bif.dma_len = LEN_W'(len); bif.dma_ready = 1'b1;
        @(negedge clk);
        bif.dma_start = 1'b0;
        check("busy_after_start", 32'(bif.dma_busy), 32'(n_eff != 0));
        if (n_eff == 0) begin
            check("zero_len_done", 32'(bif.dma_done), 32'h1);
            check("zero_len_valid", 32'(bif.dma_valid), 32'h0);
            @(negedge clk);
            check("zero_len_done_pulse", 32'(bif.dma_done), 32'h0);
            check("zero_len_idle", 32'(bif.dma_busy), 32'h0);
            return;
        end
        check("valid_not_early", 32'(bif.dma_valid), 32'h0);
        if (collide) begin
            cdata = $urandom;
            bif.req_valid = 1'b1; bif.req_write = 1'b1; bif.req_addr = base;
            bif.req_wdata = cdata; bif.req_wstrb = 4'hF;
            model_write(base, cdata, 4'hF);
        end
        got = 0; last_hs = -10; prev_stall = 1'b0; fin = 1'b0; it = 0; prev_data = 32'h0;
        while (!fin && it < 3000) begin
            if (it == 1) begin
                bif.req_valid = 1'b0; bif.req_write = 1'b0;
                check("first_valid_latency", 32'(bif.dma_valid), 32'h1);
            end
            if (prev_stall) begin
                check("stall_valid_hold", 32'(bif.dma_valid), 32'h1);
                check("stall_data_hold", bif.dma_data, prev_data);
            end
            if (bif.dma_done) begin
                check("done_timing", 32'(it), 32'(last_hs + 1));
                check("done_word_count", 32'(got), 32'(n_eff));
                check("done_idle", 32'(bif.dma_busy), 32'h0);
                fin = 1'b1;
            end else if (abort_after >= 0 && got == abort_after) begin
                bif.dma_abort = 1'b1; bif.dma_ready = 1'b0;
                @(negedge clk);
                bif.dma_abort = 1'b0;
                check("abort_valid_drop", 32'(bif.dma_valid), 32'h0);
                check("abort_done", 32'(bif.dma_done), 32'h1);
                check("abort_idle", 32'(bif.dma_busy), 32'h0);
                @(negedge clk);
                check("abort_done_pulse", 32'(bif.dma_done), 32'h0);
                check("abort_stays_empty", 32'(bif.dma_valid), 32'h0);
                fin = 1'b1;
            end else begin
                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                bif.dma_ready = r;
                if (bif.dma_valid && r) begin
                    check("dma_data", bif.dma_data, exp_q[got]);
                    check("dma_last", 32'(bif.dma_last), 32'(got == n_eff - 1));
                    got++;
                    last_hs = it;
                end
                prev_stall = bif.dma_valid && !r;
                prev_data = bif.dma_data;
                @(negedge clk);
                it++;
            end
        end
        if (!fin) check("burst_timeout", 32'h0, 32'h1);
        bif.dma_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < MEM_BYTES; i++) mref[i] = 8'h00;
        bif.req_valid = 1'b0; bif.req_write = 1'b0; bif.req_addr = 32'h0;
        bif.req_wdata = 32'h0; bif.req_wstrb = 4'h0;
        bif.dma_start = 1'b0; bif.dma_addr = 32'h0; bif.dma_len = '0;
        bif.dma_abort = 1'b0; bif.dma_ready = 1'b1;

        #23;
        check("rst_req_ready", 32'(bif.req_ready), 32'h1);
        check("rst_rvalid", 32'(bif.rvalid), 32'h0);
        check("rst_rdata", bif.rdata, 32'h0);
        check("rst_req_err", 32'(bif.req_err), 32'h0);
        check("rst_busy", 32'(bif.dma_busy), 32'h0);
        check("rst_done", 32'(bif.dma_done), 32'h0);
        check("rst_dma_valid", 32'(bif.dma_valid), 32'h0);
        check("rst_dma_last", 32'(bif.dma_last), 32'h0);
        check("rst_dma_data", bif.dma_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) bus_write(32'(4 * i), $urandom, 4'hF);
        for (int i = 0; i < 64; i++) bus_write(32'h3F00 + 32'(4 * i), $urandom, 4'hF);

        bus_write(32'h10, 32'hDEADBEEF, 4'hF);
        bus_read(32'h10, "t1_read");
        @(negedge clk);
        check("t1_rvalid_pulse", 32'(bif.rvalid), 32'h0);
        check("t1_rdata_hold", bif.rdata, 32'hDEADBEEF);
        bus_write(32'h10, 32'h000000AA, 4'b0001);
        bus_read(32'h10, "t2_strobe");
        bus_read(32'h4000, "t3_oor_read");
        bus_write(32'h4000, 32'h12345678, 4'hF);
        bus_read(32'h0, "t3_mem_intact");

        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h4000 + 32'($urandom_range(0, 4095))
                                            : 32'(4 * $urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) bus_write(a, $urandom, 4'($urandom_range(0, 15)));
            else bus_read(a, "rand_read");
        end

        run_burst(32'h3FF8, 4, 1'b0, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a = 32'(4 * $urandom_range(0, 128));
            if (i == 3) a = a | 32'h5A5A_0000;
            run_burst(a, 8, 1'b1, -1, 1'b0);
        end
        run_burst(32'h100, 16, 1'b0, 3, 1'b0);
        run_burst(32'h20, 0, 1'b0, -1, 1'b0);
        run_burst(32'h80, 16, 1'b1, 5, 1'b0);
        run_burst(32'h44, 1, 1'b0, -1, 1'b0);
        run_burst(32'h0, 300, 1'b0, -1, 1'b0);
        run_burst(32'h40, 2, 1'b0, -1, 1'b1);
        bus_read(32'h40, "collide_new_data");

        @(negedge clk);
        bif.dma_start = 1'b1; bif.dma_addr = 32'h0; bif.dma_len = LEN_W'(16); bif.dma_ready = 1'b0;
        @(negedge clk);
        bif.dma_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bif.dma_valid), 32'h0);
        check("midrst_busy", 32'(bif.dma_busy), 32'h0);
        check("midrst_req_ready", 32'(bif.req_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        bif.dma_ready = 1'b1;
        @(negedge clk);
        check("midrst_no_done", 32'(bif.dma_done), 32'h0);
        check("midrst_idle", 32'(bif.dma_busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
